// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
//   cnt_width()  : width of an occupancy counter able to hold 0..depth
//   fifo_mode_e  : read-mode selector (standard registered read or FWFT)
package fifo_pkg;

  typedef enum logic [0:0] {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Counter must represent DEPTH itself, hence one bit more than the pointer.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Simple dual-port RAM: synchronous write, asynchronous read. Contents are not reset.
// Ports:
//   clk_i   : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from raddr_i)
module fifo_ram_2p #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/almost-empty
// thresholds, overflow/underflow pulses with a sticky error, synchronous flush and
// selectable standard (1-cycle registered read) or first-word-fall-through read mode.
// Ports:
//   clk_i          : clock, all logic on posedge
//   rst_n_i        : asynchronous active-low reset
//   clr_i          : synchronous flush (pointers, count, error to 0; requests ignored)
//   wr_en_i/wdata_i: write request and data
//   rd_en_i        : read request (FWFT: pop of the head word)
//   rdata_o        : read data
//   rvalid_o       : STD: data valid this cycle; FWFT: head word present
//   full_o/empty_o : occupancy == DEPTH / == 0
//   almost_full_o  : count_o >= AFULL_TH
//   almost_empty_o : count_o <= AEMPTY_TH
//   count_o        : occupancy 0..DEPTH
//   overflow_o     : one-cycle pulse, write rejected
//   underflow_o    : one-cycle pulse, read rejected
//   error_o        : sticky OR of the pulses
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = 2,
  parameter int unsigned FWFT      = 0,
  localparam int unsigned CNT_W    = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rvalid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic             error_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             error_q, error_d;
  logic             full, empty, wr_acc, rd_acc;
  logic [WIDTH-1:0] ram_rdata;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // A read on empty is rejected even with a same-cycle write; a write on full is
  // accepted only when a read frees a slot in the same cycle. Flush masks both.
  assign rd_acc = rd_en_i & ~empty & ~clr_i;
  assign wr_acc = wr_en_i & (~full | rd_acc) & ~clr_i;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    error_d     = error_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      error_d  = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      overflow_d  = wr_en_i & ~wr_acc;
      underflow_d = rd_en_i & ~rd_acc;
      error_d     = error_q | overflow_d | underflow_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      error_q     <= error_d;
    end
  end

  fifo_ram_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(PTR_W)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (wr_acc),
    .waddr_i(wr_ptr_q),
    .wdata_i(wdata_i),
    .raddr_i(rd_ptr_q),
    .rdata_o(ram_rdata)
  );

  if (MODE == FIFO_FWFT) begin : g_fwft
    // Head word is shown directly from the RAM; zero while nothing is stored.
    assign rdata_o  = empty ? '0 : ram_rdata;
    assign rvalid_o = ~empty;
  end else begin : g_std
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) rdata_q <= ram_rdata;
      end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
  end

  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count_q >= AFULL_C);
  assign almost_empty_o = (count_q <= AEMPTY_C);
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A: defaults, standard read mode.
  logic        a_clr = 0, a_wr = 0, a_rd = 0;
  logic [15:0] a_wd = '0;
  logic [15:0] a_rdata;
  logic [4:0]  a_count;
  logic a_rvalid, a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf, a_err;

  // Instance B: FWFT, DEPTH 8, WIDTH 32.
  logic        b_clr = 0, b_wr = 0, b_rd = 0;
  logic [31:0] b_wd = '0;
  logic [31:0] b_rdata;
  logic [3:0]  b_count;
  logic b_rvalid, b_full, b_empty, b_afull, b_aempty, b_ovf, b_udf, b_err;

  sync_fifo_param u_a (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(a_clr), .wr_en_i(a_wr), .wdata_i(a_wd),
    .rd_en_i(a_rd), .rdata_o(a_rdata), .rvalid_o(a_rvalid), .full_o(a_full),
    .empty_o(a_empty), .almost_full_o(a_afull), .almost_empty_o(a_aempty),
    .count_o(a_count), .overflow_o(a_ovf), .underflow_o(a_udf), .error_o(a_err)
  );

  sync_fifo_param #(.WIDTH(32), .DEPTH(8), .FWFT(1)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(b_clr), .wr_en_i(b_wr), .wdata_i(b_wd),
    .rd_en_i(b_rd), .rdata_o(b_rdata), .rvalid_o(b_rvalid), .full_o(b_full),
    .empty_o(b_empty), .almost_full_o(b_afull), .almost_empty_o(b_aempty),
    .count_o(b_count), .overflow_o(b_ovf), .underflow_o(b_udf), .error_o(b_err)
  );

  // Reference models: scoreboard queues hold the words expected to come out.
  logic [15:0] sba[$];
  int          ma_cnt = 0;
  logic        ma_err = 0;
  logic [15:0] ma_last = '0;
  logic [31:0] sbb[$];
  int          mb_cnt = 0;
  logic        mb_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input logic rv, input logic ovf, input logic udf);
    chk("a_count", 64'(a_count), 64'(ma_cnt));
    chk("a_rvalid", 64'(a_rvalid), 64'(rv));
    chk("a_rdata", 64'(a_rdata), 64'(ma_last));
    chk("a_full", 64'(a_full), 64'(ma_cnt == 16));
    chk("a_empty", 64'(a_empty), 64'(ma_cnt == 0));
    chk("a_afull", 64'(a_afull), 64'(ma_cnt >= 14));
    chk("a_aempty", 64'(a_aempty), 64'(ma_cnt <= 2));
    chk("a_overflow", 64'(a_ovf), 64'(ovf));
    chk("a_underflow", 64'(a_udf), 64'(udf));
    chk("a_error", 64'(a_err), 64'(ma_err));
  endtask

  task automatic check_b(input logic ovf, input logic udf);
    chk("b_count", 64'(b_count), 64'(mb_cnt));
    chk("b_rvalid", 64'(b_rvalid), 64'(mb_cnt != 0));
    if (mb_cnt != 0) chk("b_rdata", 64'(b_rdata), 64'(sbb[0]));
    chk("b_full", 64'(b_full), 64'(mb_cnt == 8));
    chk("b_empty", 64'(b_empty), 64'(mb_cnt == 0));
    chk("b_afull", 64'(b_afull), 64'(mb_cnt >= 6));
    chk("b_aempty", 64'(b_aempty), 64'(mb_cnt <= 2));
    chk("b_overflow", 64'(b_ovf), 64'(ovf));
    chk("b_underflow", 64'(b_udf), 64'(udf));
    chk("b_error", 64'(b_err), 64'(mb_err));
  endtask

  task automatic reset_models();
    sba.delete();
    ma_cnt = 0;
    ma_err = 0;
    ma_last = '0;
    sbb.delete();
    mb_cnt = 0;
    mb_err = 0;
  endtask

  // One clock on instance A; model updated from the stimulus, outputs checked #1 after.
  task automatic cyc_a(input logic clr, input logic wr, input logic [15:0] wd, input logic rd);
    logic racc, wacc, ovf, udf;
    racc = !clr && rd && (ma_cnt != 0);
    wacc = !clr && wr && (ma_cnt < 16 || racc);
    ovf  = !clr && wr && !wacc;
    udf  = !clr && rd && !racc;
    if (racc) ma_last = sba.pop_front();
    if (wacc) sba.push_back(wd);
    if (clr) begin
      sba.delete();
      ma_cnt = 0;
      ma_err = 0;
    end else begin
      ma_cnt = ma_cnt + int'(wacc) - int'(racc);
      ma_err = ma_err | ovf | udf;
    end
    a_clr = clr; a_wr = wr; a_wd = wd; a_rd = rd;
    @(posedge clk);
    #1;
    a_clr = 0; a_wr = 0; a_rd = 0;
    check_a(racc, ovf, udf);
  endtask

  task automatic cyc_b(input logic wr, input logic [31:0] wd, input logic rd);
    logic racc, wacc, ovf, udf;
    racc = rd && (mb_cnt != 0);
    wacc = wr && (mb_cnt < 8 || racc);
    ovf  = wr && !wacc;
    udf  = rd && !racc;
    if (racc) void'(sbb.pop_front());
    if (wacc) sbb.push_back(wd);
    mb_cnt = mb_cnt + int'(wacc) - int'(racc);
    mb_err = mb_err | ovf | udf;
    b_wr = wr; b_wd = wd; b_rd = rd;
    @(posedge clk);
    #1;
    b_wr = 0; b_rd = 0;
    check_b(ovf, udf);
  endtask

  initial begin
    // Reset values, both instances.
    #12;
    check_a(1'b0, 1'b0, 1'b0);
    check_b(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill 1..16, then overflow attempt.
    for (int i = 1; i <= 16; i++) cyc_a(1'b0, 1'b1, 16'(i), 1'b0);
    cyc_a(1'b0, 1'b1, 16'hBEEF, 1'b0);
    cyc_a(1'b0, 1'b0, 16'h0, 1'b0);

    // 17 reads: data 1..16, last one underflows with rdata held.
    for (int i = 0; i < 17; i++) cyc_a(1'b0, 1'b0, 16'h0, 1'b1);

    // Refill, then simultaneous read/write at full across pointer wrap.
    for (int i = 0; i < 16; i++) cyc_a(1'b0, 1'b1, 16'(16'h0100 + i), 1'b0);
    for (int i = 0; i < 20; i++) cyc_a(1'b0, 1'b1, 16'(16'h0200 + i), 1'b1);
    for (int i = 0; i < 16; i++) cyc_a(1'b0, 1'b0, 16'h0, 1'b1);

    // Empty with simultaneous read/write.
    cyc_a(1'b0, 1'b1, 16'h1234, 1'b1);

    // Bring count to 5 (error already sticky), then flush with ignored requests.
    for (int i = 0; i < 4; i++) cyc_a(1'b0, 1'b1, 16'(16'h0300 + i), 1'b0);
    cyc_a(1'b1, 1'b1, 16'hDEAD, 1'b1);
    cyc_a(1'b0, 1'b0, 16'h0, 1'b1);
    cyc_a(1'b1, 1'b0, 16'h0, 1'b0);

    // FWFT instance.
    cyc_b(1'b1, 32'hA5A5A5A5, 1'b0);
    cyc_b(1'b0, 32'h0, 1'b1);
    cyc_b(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 9; i++) cyc_b(1'b1, 32'(32'h1000 + i), 1'b0);
    for (int i = 0; i < 3; i++) cyc_b(1'b0, 32'h0, 1'b1);
    cyc_b(1'b1, 32'h2222, 1'b1);

    // Traffic, then asynchronous reset between edges.
    for (int i = 0; i < 3; i++) cyc_a(1'b0, 1'b1, 16'(16'h0400 + i), 1'b0);
    cyc_a(1'b0, 1'b0, 16'h0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    reset_models();
    check_a(1'b0, 1'b0, 1'b0);
    check_b(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Post-reset traffic: first write lands at address 0 and reads back in order.
    cyc_a(1'b0, 1'b1, 16'h5A5A, 1'b0);
    cyc_a(1'b0, 1'b1, 16'h6B6B, 1'b0);
    cyc_a(1'b0, 1'b0, 16'h0, 1'b1);
    cyc_a(1'b0, 1'b0, 16'h0, 1'b1);
    cyc_b(1'b1, 32'hCAFEF00D, 1'b0);
    cyc_b(1'b0, 32'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, fully parametrised FIFO. Successor to the team's fixed 16x16 FIFO; the async variant remains in use for clock crossings.
- Adds generic width/depth, an occupancy count, programmable almost-full/almost-empty thresholds, and selectable standard or first-word-fall-through (FWFT) read mode.
- Adds separate overflow/underflow pulses with a sticky error, and a synchronous flush.
- Used as the default buffering element between same-clock pipeline stages.

Parameters:
- WIDTH, 16, data width in bits (>=1)
- DEPTH, 16, number of entries; power of two, >=2
- AFULL_TH, DEPTH-2, almost_full_o asserts when count_o >= AFULL_TH
- AEMPTY_TH, 2, almost_empty_o asserts when count_o <= AEMPTY_TH
- FWFT, 0, 0 = standard read mode (1-cycle latency), 1 = first-word-fall-through

Ports:
- clk_i  input  1  single clock; all logic on posedge
- rst_n_i  input  1  reset, asynchronous assert, active-low
- clr_i  input  1  synchronous flush: pointers/count to 0, sticky error cleared
- wr_en_i  input  1  write request
- wdata_i  input  WIDTH  write data
- rd_en_i  input  1  read request (FWFT: pop/acknowledge of head word)
- rdata_o  output  WIDTH  read data
- rvalid_o  output  1  standard mode: rdata_o valid this cycle; FWFT mode: head word present (= !empty_o)
- full_o  output  1  count_o == DEPTH
- empty_o  output  1  count_o == 0
- almost_full_o  output  1  count_o >= AFULL_TH
- almost_empty_o  output  1  count_o <= AEMPTY_TH
- count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow_o  output  1  one-cycle pulse: write rejected
- underflow_o  output  1  one-cycle pulse: read rejected
- error_o  output  1  sticky OR of overflow/underflow; cleared by reset or clr_i

Behaviour:
- Reset (rst_n_i low, async):
  - rdata_o = 0, rvalid_o = 0, count_o = 0, empty_o = 1, almost_empty_o = 1.
  - full_o = 0, almost_full_o = 0 (unless AFULL_TH == 0), overflow_o = 0, underflow_o = 0, error_o = 0.
  - Memory contents are not reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count_o is a registered up/down counter. All flags are combinational decodes of count_o, so they update in the cycle after the causing edge.
- Write acceptance: wr_acc = wr_en_i & (!full_o | rd_acc). Writing while full is allowed only if a read is accepted in the same cycle.
- Read acceptance: rd_acc = rd_en_i & !empty_o. A read on empty is rejected even if a write is accepted in the same cycle.
- count update:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged when both or neither are accepted
- Rejected write: overflow_o = 1 for the next cycle; no pointer or memory change.
- Rejected read: underflow_o = 1 for the next cycle; rdata_o holds its value.
- error_o sets on either pulse and holds until clr_i or reset. clr_i has priority over a same-cycle pulse.
- Standard mode (FWFT=0):
  - rdata_o <= mem[rd_ptr] on rd_acc; rvalid_o = 1 for exactly the next cycle.
  - rdata_o holds its value when there is no read.
- FWFT mode (FWFT=1):
  - rdata_o = mem[rd_ptr] combinationally while !empty_o; rvalid_o = !empty_o.
  - rd_acc advances to the next word, visible in the following cycle.
  - When empty, the first write appears on rdata_o one cycle after the write edge (memory write latency).
- clr_i:
  - Pointers, count and error_o go to 0 at the next edge; rvalid_o and the pulses go to 0.
  - Any same-cycle wr_en_i/rd_en_i is ignored.
- Reset mid-operation: all state is discarded immediately; the first post-reset write lands at address 0.
- No state machine is needed. State consists of wr_ptr, rd_ptr, count, the read register and the error flags.

Decomposition:
- Package fifo_pkg: function clog2-based width helper, and a localparam CNT_W = $clog2(DEPTH)+1 computed per instance.
- Package fifo_pkg also holds the enum fifo_mode_e {FIFO_STD, FIFO_FWFT} for documentation and bench use.
- Sub-module fifo_ram_2p: simple dual-port RAM, synchronous write, asynchronous read (WIDTH, DEPTH params). It is instantiated once; the read-register and FWFT selection live in the top level.

Test Plan:
- Defaults, FWFT=0: write 16 words 0x0001..0x0010 -> full_o=1, count_o=16, almost_full_o from count 14. Write 0xBEEF -> overflow_o pulse, error_o=1, data unchanged.
- Read 17 times after the fill above -> rdata_o 0x0001..0x0010, each with a rvalid_o pulse one cycle after rd_en_i. The 17th read -> underflow_o pulse, rdata_o stays 0x0010.
- Full with simultaneous wr_en_i/rd_en_i for 20 cycles with an incrementing pattern -> count_o stays 16, no overflow_o, data order preserved across pointer wrap.
- Empty with simultaneous wr_en_i/rd_en_i -> write accepted, underflow_o=1, count_o=1.
- FWFT=1, DEPTH=8, WIDTH=32: write 0xA5A5A5A5 into empty -> rvalid_o=1 and rdata_o=0xA5A5A5A5 one cycle later with no rd_en_i; rd_en_i -> empty_o=1 next cycle.
- Mid-traffic: assert clr_i with count_o=5 and error_o=1 -> count_o=0, error_o=0, empty_o=1. Then async rst_n_i low between edges -> outputs reach reset values before the next edge.
